pll_lock_reset_seq: RTL and testbench
=====================================

# pll_lock_reset_seq

Bring-up and supervision controller for the fabric CCC/PLL. It powers the PLL up through a timed power-down pulse and waits for lock with a timeout and bounded retries. It requires lock to stay stable for a settle window before releasing the fabric reset, then watches for lock loss and re-sequences on loss. It runs on a free-running clock independent of the PLL output and drives the PLL `POWERDOWN_N` input and the downstream fabric reset.

## Interface
- `PD_CYCLES`, 16: cycles `PLL_POWERDOWN_N` is held low per power cycle (≥1).
- `LOCK_TIMEOUT`, 50000: cycles allowed in WAIT_LOCK before a retry (≥1).
- `SETTLE_CYCLES`, 1024: consecutive cycles of synchronized lock required before RUN (≥1).
- `MAX_RETRIES`, 3: power-cycle retries after the first attempt before FAULT (0..15).
- `CNT_W`, 16: width of the shared state timer; must hold max(PD_CYCLES, LOCK_TIMEOUT, SETTLE_CYCLES)−1.
- `CLK` input 1: free-running clock (not the PLL output).
- `ARST_N` input 1: asynchronous, active-low reset.
- `PLL_LOCK` input 1: PLL lock, asynchronous to CLK; synchronized internally with 2 flops.
- `INIT_DONE` input 1: device init complete, level; sequencing starts only when high.
- `RESTART` input 1: single-cycle request to re-sequence from PWRDN.
- `PLL_POWERDOWN_N` output 1: to PLL `POWERDOWN_N`.
- `FABRIC_RESET_N` output 1: active-low fabric reset, high only in RUN.
- `LOCK_STABLE` output 1: high only in RUN.
- `FAULT` output 1: high only in FAULT.
- `RETRY_CNT` output 4: timeouts taken in the current bring-up.
- `LOSS_CNT` output 8: lock losses seen in RUN, saturating at 255.

## Operation
- Reset values: state IDLE, timer 0, sync flops 0. `PLL_POWERDOWN_N`, `FABRIC_RESET_N`, `LOCK_STABLE`, `FAULT`, `RETRY_CNT` and `LOSS_CNT` are all 0.
- Registered Moore outputs: `PLL_POWERDOWN_N`=1 in WAIT_LOCK, SETTLE and RUN. `FABRIC_RESET_N`=`LOCK_STABLE`=1 in RUN. `FAULT`=1 in FAULT.
- The timer clears on every state entry and increments each cycle otherwise. `lock_s` is the 2-flop synchronized `PLL_LOCK`.
- IDLE: when `INIT_DONE`=1, go to PWRDN.
- PWRDN: when timer == PD_CYCLES−1, go to WAIT_LOCK. This gives exactly PD_CYCLES cycles low.
- WAIT_LOCK:
  - `lock_s`=1: go to SETTLE.
  - Otherwise, at timer == LOCK_TIMEOUT−1: if `RETRY_CNT` == MAX_RETRIES, go to FAULT; else increment `RETRY_CNT` and go to PWRDN.
- SETTLE:
  - `lock_s`=0: return to WAIT_LOCK with a fresh timeout. This is not counted as a retry.
  - `lock_s`=1 at timer == SETTLE_CYCLES−1: go to RUN and clear `RETRY_CNT`.
- RUN: on `lock_s`=0, go to WAIT_LOCK and increment `LOSS_CNT` (saturating). The PLL stays powered; the timeout/retry path handles non-recovery.
- FAULT: PLL held powered down. Only `RESTART` or `ARST_N` leaves this state.
- `RESTART` priority: in any state except IDLE, `RESTART`=1 forces PWRDN and clears `RETRY_CNT`. It overrides every other transition in that cycle; a simultaneous RUN lock loss does not increment `LOSS_CNT`. `RESTART` is ignored in IDLE.
- `INIT_DONE` is sampled only in IDLE. A later deassert has no effect.
- `LOSS_CNT` is cleared only by `ARST_N`.

## Timing
- Lock-rise path: `PLL_LOCK` rises before edge k, `lock_s` is high after edge k+1, and SETTLE is entered at edge k+2.
- Settle path: RUN is entered SETTLE_CYCLES edges after SETTLE entry; `FABRIC_RESET_N` rises on that same edge.
- Lock-loss path: `PLL_LOCK` falls before edge k, and `FABRIC_RESET_N`/`LOCK_STABLE` fall at edge k+2 (2 sync edges plus the transition edge). Worst case is 3 CLK periods from the async fall.
- `RESTART` sampled at edge k: state is PWRDN and `PLL_POWERDOWN_N`=0 after edge k.
- Full failed attempt (WAIT_LOCK entry to next WAIT_LOCK entry) = LOCK_TIMEOUT + PD_CYCLES cycles.
- `ARST_N` assertion asynchronously forces all reset values, including mid-SETTLE or mid-RUN. Deassertion is synchronized by the top-level reset bridge; the block does no synchronization of its own.

## Test plan
Bench parameters: PD_CYCLES=4, LOCK_TIMEOUT=20, SETTLE_CYCLES=8, MAX_RETRIES=2.
- Normal bring-up: `INIT_DONE`=1, then `PLL_LOCK` rises 10 cycles into WAIT_LOCK → `PLL_POWERDOWN_N` low exactly 4 cycles; SETTLE entered 2 edges after the lock rise; `FABRIC_RESET_N`=1 exactly 8 cycles after SETTLE entry; `RETRY_CNT`=0.
- No lock: `PLL_LOCK`=0 throughout → 3 PWRDN pulses; `RETRY_CNT` steps 1, 2; FAULT after the third timeout with `FAULT`=1, `PLL_POWERDOWN_N`=0, `RETRY_CNT`=2. Then pulse `RESTART` → PWRDN, `RETRY_CNT`=0, `FAULT`=0.
- Settle glitch: `PLL_LOCK` drops for 1 cycle at SETTLE timer 5 → back to WAIT_LOCK, no retry counted; RUN reached 8 cycles after lock resumes plus 2 sync edges.
- Lock loss in RUN: drop `PLL_LOCK` → `FABRIC_RESET_N`=0 within 3 cycles and `LOSS_CNT`=1. Relock → RUN again. Repeating 300 losses leaves `LOSS_CNT`=255.
- Simultaneous events: `RESTART` in the same cycle that `lock_s` falls in RUN → PWRDN and `LOSS_CNT` unchanged. `RESTART` in IDLE → ignored.
- Async reset mid-SETTLE: assert `ARST_N`=0 between edges → all outputs 0 immediately and state IDLE; after release with `INIT_DONE`=1, the full sequence repeats.

Source files
------------

// File: rtl/pll_lock_reset_seq.sv
// PLL bring-up and supervision: timed power-down pulse, lock wait with bounded
// retries, lock settle window, fabric reset release and lock-loss re-sequencing.
module pll_lock_reset_seq #(
  parameter int PD_CYCLES     = 16,
  parameter int LOCK_TIMEOUT  = 50000,
  parameter int SETTLE_CYCLES = 1024,
  parameter int MAX_RETRIES   = 3,
  parameter int CNT_W         = 16
) (
  input  logic       CLK,
  input  logic       ARST_N,
  input  logic       PLL_LOCK,
  input  logic       INIT_DONE,
  input  logic       RESTART,
  output logic       PLL_POWERDOWN_N,
  output logic       FABRIC_RESET_N,
  output logic       LOCK_STABLE,
  output logic       FAULT,
  output logic [3:0] RETRY_CNT,
  output logic [7:0] LOSS_CNT
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PWRDN,
    S_WAIT_LOCK,
    S_SETTLE,
    S_RUN,
    S_FAULT
  } state_t;

  localparam logic [CNT_W-1:0] PD_LAST     = CNT_W'(PD_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [3:0]       RETRY_MAX   = 4'(MAX_RETRIES);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] timer;
  logic             lock_meta_p0;
  logic             lock_s;
  logic [3:0]       retry_nxt;
  logic [7:0]       loss_nxt;
  logic             restart_take;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // PLL_LOCK is asynchronous to CLK: two-flop synchronizer
  always_ff @(posedge CLK or negedge ARST_N) begin
    if (!ARST_N) begin
      lock_meta_p0 <= 1'b0;
      lock_s       <= 1'b0;
    end else begin
      lock_meta_p0 <= PLL_LOCK;
      lock_s       <= lock_meta_p0;
    end
  end

  always_comb begin
    state_nxt    = state;
    retry_nxt    = RETRY_CNT;
    loss_nxt     = LOSS_CNT;
    restart_take = RESTART && (state != S_IDLE);
    if (restart_take) begin
      state_nxt = S_PWRDN;
      retry_nxt = '0;
    end else begin
      case (state)
        S_IDLE:      if (INIT_DONE) state_nxt = S_PWRDN;
        S_PWRDN:     if (timer == PD_LAST) state_nxt = S_WAIT_LOCK;
        S_WAIT_LOCK: begin
          if (lock_s) begin
            state_nxt = S_SETTLE;
          end else if (timer == TIMEOUT_LAST) begin
            if (RETRY_CNT == RETRY_MAX) begin
              state_nxt = S_FAULT;
            end else begin
              state_nxt = S_PWRDN;
              retry_nxt = RETRY_CNT + 4'd1;
            end
          end
        end
        // A lock drop during settle restarts the wait without costing a retry
        S_SETTLE: begin
          if (!lock_s) begin
            state_nxt = S_WAIT_LOCK;
          end else if (timer == SETTLE_LAST) begin
            state_nxt = S_RUN;
            retry_nxt = '0;
          end
        end
        S_RUN: begin
          if (!lock_s) begin
            state_nxt = S_WAIT_LOCK;
            loss_nxt  = sat_inc8(LOSS_CNT);
          end
        end
        S_FAULT:     state_nxt = S_FAULT;
        default:     state_nxt = S_IDLE;
      endcase
    end
  end

  // State, timer, counters and Moore outputs decoded from the next state
  always_ff @(posedge CLK or negedge ARST_N) begin
    if (!ARST_N) begin
      state           <= S_IDLE;
      timer           <= '0;
      RETRY_CNT       <= '0;
      LOSS_CNT        <= '0;
      PLL_POWERDOWN_N <= 1'b0;
      FABRIC_RESET_N  <= 1'b0;
      LOCK_STABLE     <= 1'b0;
      FAULT           <= 1'b0;
    end else begin
      state           <= state_nxt;
      timer           <= ((state_nxt != state) || restart_take) ? '0 : timer + CNT_W'(1);
      RETRY_CNT       <= retry_nxt;
      LOSS_CNT        <= loss_nxt;
      PLL_POWERDOWN_N <= (state_nxt == S_WAIT_LOCK) || (state_nxt == S_SETTLE) ||
                         (state_nxt == S_RUN);
      FABRIC_RESET_N  <= (state_nxt == S_RUN);
      LOCK_STABLE     <= (state_nxt == S_RUN);
      FAULT           <= (state_nxt == S_FAULT);
    end
  end

endmodule

// File: tb/tb_pll_lock_reset_seq.sv
// Directed bench for pll_lock_reset_seq: stimulus schedules expected output
// vectors per clock edge into a scoreboard; a negedge monitor compares them.
module tb_pll_lock_reset_seq;

  logic       CLK = 1'b0;
  logic       ARST_N = 1'b0;
  logic       PLL_LOCK = 1'b0;
  logic       INIT_DONE = 1'b0;
  logic       RESTART = 1'b0;
  logic       PLL_POWERDOWN_N;
  logic       FABRIC_RESET_N;
  logic       LOCK_STABLE;
  logic       FAULT;
  logic [3:0] RETRY_CNT;
  logic [7:0] LOSS_CNT;

  pll_lock_reset_seq #(
    .PD_CYCLES(4),
    .LOCK_TIMEOUT(20),
    .SETTLE_CYCLES(8),
    .MAX_RETRIES(2),
    .CNT_W(16)
  ) dut (
    .CLK(CLK),
    .ARST_N(ARST_N),
    .PLL_LOCK(PLL_LOCK),
    .INIT_DONE(INIT_DONE),
    .RESTART(RESTART),
    .PLL_POWERDOWN_N(PLL_POWERDOWN_N),
    .FABRIC_RESET_N(FABRIC_RESET_N),
    .LOCK_STABLE(LOCK_STABLE),
    .FAULT(FAULT),
    .RETRY_CNT(RETRY_CNT),
    .LOSS_CNT(LOSS_CNT)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    string       name;
    int          cyc;
    logic [15:0] exp;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad = 0;

  logic [15:0] outv;
  assign outv = {PLL_POWERDOWN_N, FABRIC_RESET_N, LOCK_STABLE, FAULT, RETRY_CNT, LOSS_CNT};

  // Vector layout: {pd_n, fabric_rst_n, lock_stable, fault, retry[3:0], loss[7:0]}
  function automatic logic [15:0] ov(bit pd, bit fr, bit ls, bit f, int rc, int lc);
    return {pd, fr, ls, f, 4'(rc), 8'(lc)};
  endfunction

  function automatic int sat(int n);
    return (n > 255) ? 255 : n;
  endfunction

  task automatic expect_at(input string nm, input int c, input logic [15:0] e);
    exp_t t;
    t.name = nm;
    t.cyc  = c;
    t.exp  = e;
    sb.push_back(t);
  endtask

  task automatic at(input int n);
    while (cyc < n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  // Monitor: compares every scheduled expectation once its edge has passed
  always @(negedge CLK) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc <= cyc) begin
        total++;
        if (outv !== sb[i].exp) begin
          bad++;
          $display("FAIL %s cyc=%0d got=%h required=%h", sb[i].name, cyc, outv, sb[i].exp);
        end
        sb.delete(i);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog cyc=%0d got=timeout required=finish", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int a, q, w1, e, s, g, n, d;

    // Reset state, then RESTART in IDLE must be ignored
    expect_at("reset", 2, ov(0, 0, 0, 0, 0, 0));
    at(3);
    ARST_N = 1'b1;
    at(4);
    RESTART = 1'b1;
    at(5);
    RESTART = 1'b0;
    expect_at("idle_restart_ignored", 11, ov(0, 0, 0, 0, 0, 0));

    // Normal bring-up: PWRDN 13..16, WAIT_LOCK at 17, lock at +10
    at(12);
    total++;
    if (outv !== ov(0, 0, 0, 0, 0, 0)) begin
      bad++;
      $display("FAIL idle_direct cyc=%0d got=%h required=%h", cyc, outv, ov(0, 0, 0, 0, 0, 0));
    end
    INIT_DONE = 1'b1;
    expect_at("pd_low_last", 16, ov(0, 0, 0, 0, 0, 0));
    expect_at("pd_high", 17, ov(1, 0, 0, 0, 0, 0));
    expect_at("settle_before_run", 37, ov(1, 0, 0, 0, 0, 0));
    expect_at("run_entry", 38, ov(1, 1, 1, 0, 0, 0));
    at(27);
    PLL_LOCK = 1'b1;

    // First lock loss in RUN, then relock
    expect_at("loss1_still_run", 42, ov(1, 1, 1, 0, 0, 0));
    expect_at("loss1_drop", 43, ov(1, 0, 0, 0, 0, 1));
    expect_at("relock_settle", 54, ov(1, 0, 0, 0, 0, 1));
    expect_at("relock_run", 55, ov(1, 1, 1, 0, 0, 1));
    at(40);
    PLL_LOCK = 1'b0;
    at(44);
    PLL_LOCK = 1'b1;

    // RESTART coincident with lock_s falling in RUN: no loss counted
    expect_at("simul_pre", 59, ov(1, 1, 1, 0, 0, 1));
    expect_at("simul_pwrdn", 60, ov(0, 0, 0, 0, 0, 1));
    expect_at("simul_pd_last", 63, ov(0, 0, 0, 0, 0, 1));
    expect_at("simul_wait", 64, ov(1, 0, 0, 0, 0, 1));
    expect_at("simul_run", 75, ov(1, 1, 1, 0, 0, 1));
    at(57);
    PLL_LOCK = 1'b0;
    at(59);
    RESTART = 1'b1;
    at(60);
    RESTART = 1'b0;
    at(64);
    PLL_LOCK = 1'b1;

    // Repeated losses up to 300 total; LOSS_CNT saturates at 255
    a = 75;
    for (n = 2; n <= 300; n++) begin
      at(a);
      PLL_LOCK = 1'b0;
      expect_at("loss_wait", a + 3, ov(1, 0, 0, 0, 0, sat(n)));
      expect_at("loss_run", a + 14, ov(1, 1, 1, 0, 0, sat(n)));
      at(a + 3);
      PLL_LOCK = 1'b1;
      a = a + 14;
    end
    at(a);
    total++;
    if (outv !== ov(1, 1, 1, 0, 0, 255)) begin
      bad++;
      $display("FAIL loss_sat_direct cyc=%0d got=%h required=%h", cyc, outv, ov(1, 1, 1, 0, 0, 255));
    end

    // No lock: restart, three PWRDN pulses, then FAULT
    q = a;
    PLL_LOCK = 1'b0;
    RESTART = 1'b1;
    at(q + 1);
    RESTART = 1'b0;
    w1 = q + 5;
    expect_at("nolock_wait1", w1, ov(1, 0, 0, 0, 0, 255));
    expect_at("nolock_to1_pre", w1 + 19, ov(1, 0, 0, 0, 0, 255));
    expect_at("nolock_retry1", w1 + 20, ov(0, 0, 0, 0, 1, 255));
    expect_at("nolock_pd2_last", w1 + 23, ov(0, 0, 0, 0, 1, 255));
    expect_at("nolock_wait2", w1 + 24, ov(1, 0, 0, 0, 1, 255));
    expect_at("nolock_to2_pre", w1 + 43, ov(1, 0, 0, 0, 1, 255));
    expect_at("nolock_retry2", w1 + 44, ov(0, 0, 0, 0, 2, 255));
    expect_at("nolock_wait3", w1 + 48, ov(1, 0, 0, 0, 2, 255));
    expect_at("nolock_to3_pre", w1 + 67, ov(1, 0, 0, 0, 2, 255));
    expect_at("fault_entry", w1 + 68, ov(0, 0, 0, 1, 2, 255));
    expect_at("fault_hold", w1 + 80, ov(0, 0, 0, 1, 2, 255));
    expect_at("fault_restart", w1 + 81, ov(0, 0, 0, 0, 0, 255));
    at(w1 + 80);
    total++;
    if (outv !== ov(0, 0, 0, 1, 2, 255)) begin
      bad++;
      $display("FAIL fault_direct cyc=%0d got=%h required=%h", cyc, outv, ov(0, 0, 0, 1, 2, 255));
    end
    RESTART = 1'b1;
    at(w1 + 81);
    RESTART = 1'b0;

    // Settle glitch at SETTLE timer 5
    e = w1 + 81;
    s = e + 7;
    expect_at("glitch_wait", e + 4, ov(1, 0, 0, 0, 0, 255));
    expect_at("glitch_no_early_run", s + 8, ov(1, 0, 0, 0, 0, 255));
    expect_at("glitch_settle_pre", s + 16, ov(1, 0, 0, 0, 0, 255));
    expect_at("glitch_run", s + 17, ov(1, 1, 1, 0, 0, 255));
    at(e + 4);
    PLL_LOCK = 1'b1;
    at(s + 5);
    PLL_LOCK = 1'b0;
    at(s + 6);
    PLL_LOCK = 1'b1;

    // Async reset mid-SETTLE, then the full sequence again
    g = s + 17;
    at(g);
    PLL_LOCK = 1'b0;
    expect_at("pre_rst_wait", g + 3, ov(1, 0, 0, 0, 0, 255));
    at(g + 3);
    PLL_LOCK = 1'b1;
    at(g + 8);
    #2;
    ARST_N = 1'b0;
    #1;
    total++;
    if (outv !== ov(0, 0, 0, 0, 0, 0)) begin
      bad++;
      $display("FAIL async_rst_direct cyc=%0d got=%h required=%h", cyc, outv, ov(0, 0, 0, 0, 0, 0));
    end
    expect_at("async_rst_now", g + 8, ov(0, 0, 0, 0, 0, 0));
    expect_at("async_rst_hold", g + 9, ov(0, 0, 0, 0, 0, 0));
    expect_at("rerun_pd_last", g + 14, ov(0, 0, 0, 0, 0, 0));
    expect_at("rerun_wait", g + 15, ov(1, 0, 0, 0, 0, 0));
    expect_at("rerun_settle", g + 23, ov(1, 0, 0, 0, 0, 0));
    expect_at("rerun_run", g + 24, ov(1, 1, 1, 0, 0, 0));
    at(g + 10);
    ARST_N = 1'b1;

    // Drain the scoreboard with a bounded wait
    at(g + 26);
    total++;
    if (outv !== ov(1, 1, 1, 0, 0, 0)) begin
      bad++;
      $display("FAIL rerun_direct cyc=%0d got=%h required=%h", cyc, outv, ov(1, 1, 1, 0, 0, 0));
    end
    d = 0;
    while (sb.size() != 0 && d < 20) begin
      @(posedge CLK);
      d++;
    end
    while (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain_%s cyc=%0d got=unchecked required=checked", sb[0].name, cyc);
      sb.delete(0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
